// File: rtl/signed_mult_ctrl.sv
// signed_mult_ctrl: sequencer for a shift-add sign-magnitude multiplier datapath.
// Holds the operands, strobes the datapath and forms the signed 16-bit result.
module signed_mult_ctrl #(
    parameter int MAX_ITER = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic [7:0]  mplier,
    output logic [7:0]  mcand,
    output logic        load,
    output logic        psel,
    output logic        reg_en,
    output logic        shift_en,
    input  logic        zflag,
    input  logic [14:0] product,
    input  logic        sign,
    output logic [15:0] result,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int CW = $clog2(MAX_ITER + 1);
    typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_mplier, r_mcand;
    logic [15:0]   r_result;
    logic          r_load, r_psel, r_reg_en, r_shift_en, r_busy, r_done, r_err;
    logic [15:0]   w_mag;
    logic          w_timeout;
    assign w_mag     = {1'b0, product};
    assign w_timeout = r_cnt == CW'(MAX_ITER);
    assign mplier    = r_mplier;
    assign mcand     = r_mcand;
    assign load      = r_load;
    assign psel      = r_psel;
    assign reg_en    = r_reg_en;
    assign shift_en  = r_shift_en;
    assign result    = r_result;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    // Strobes are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mplier   <= '0;
            r_mcand    <= '0;
            r_result   <= '0;
            r_load     <= 1'b0;
            r_psel     <= 1'b0;
            r_reg_en   <= 1'b0;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_load     <= 1'b0;
            r_psel     <= 1'b0;
            r_reg_en   <= 1'b0;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            if (abort) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    LOAD: begin
                        r_state  <= ADD;
                        r_reg_en <= 1'b1;
                        r_psel   <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                    ADD: begin
                        if (zflag || w_timeout) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_err    <= !zflag;
                            r_result <= sign ? -w_mag : w_mag;
                        end else begin
                            r_state    <= SHIFT;
                            r_shift_en <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        r_state  <= ADD;
                        r_cnt    <= r_cnt + CW'(1);
                        r_reg_en <= 1'b1;
                        r_psel   <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                    default: begin
                        if (start) begin
                            r_state  <= LOAD;
                            r_mplier <= a_in;
                            r_mcand  <= b_in;
                            r_cnt    <= '0;
                            r_err    <= 1'b0;
                            r_load   <= 1'b1;
                            r_reg_en <= 1'b1;
                            r_busy   <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end
endmodule
